// File: rtl/mult_hilo_unit.sv
// rtl/mult_hilo_unit.sv - sequential radix-2 shift-add multiplier with HI/LO result registers
module mult_hilo_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]   ONE_W   = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_P   = (2*WIDTH)'(1);
    localparam logic [CNT_W-1:0]   ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_TOP = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic               neg_q, neg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] product, result;

    // The most negative operand negates to itself, which is its exact unsigned magnitude.
    assign abs_a   = (is_signed && srca[WIDTH-1]) ? (~srca + ONE_W) : srca;
    assign abs_b   = (is_signed && srcb[WIDTH-1]) ? (~srcb + ONE_W) : srcb;
    assign sum     = {1'b0, acc_hi_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    assign product = {acc_hi_q, mplier_q};
    assign result  = neg_q ? (~product + ONE_P) : product;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_hi_d = acc_hi_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = abs_a;
                    mplier_d = abs_b;
                    neg_d    = is_signed & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                    acc_hi_d = '0;
                    cnt_d    = CNT_TOP;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                // Carry shifts into acc_hi's MSB; the consumed multiplier bit falls off the bottom.
                acc_hi_d = sum[WIDTH:1];
                mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
            end
            S_DONE: begin
                hi_d    = result[2*WIDTH-1:WIDTH];
                lo_d    = result[WIDTH-1:0];
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_hi_q <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_hi_q <= acc_hi_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign stall = reset & (((state_q == S_IDLE) & start) | (state_q == S_RUN));
    assign done  = reset & (state_q == S_DONE);
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
